// File: rtl/acc_pkg.sv
// Frame geometry shared by the input parser and the output packer so both
// ends agree on how narrow result words map onto wide stream words.
package acc_pkg;

    localparam int IN_WIDTH   = 144;
    localparam int OUT_WIDTH  = 512;
    localparam int WORD_NUM   = 9;
    localparam int IN_NUM     = OUT_WIDTH * WORD_NUM / IN_WIDTH;
    localparam int ACC_WIDTH  = OUT_WIDTH + IN_WIDTH;
    localparam int FILL_WIDTH = 10;

endpackage

// File: rtl/packer_insert.sv
// Writes a narrow word into the packing register at a variable bit offset;
// bits outside the inserted field pass through unchanged.
module packer_insert #(
    parameter int ACC_WIDTH = 656,
    parameter int IN_WIDTH  = 144,
    parameter int POS_WIDTH = 10
) (
    input  logic [ACC_WIDTH-1:0] base,
    input  logic [POS_WIDTH-1:0] pos,
    input  logic [IN_WIDTH-1:0]  data,
    input  logic                 en,
    output logic [ACC_WIDTH-1:0] result
);

    logic [ACC_WIDTH-1:0] data_ext_s;
    logic [ACC_WIDTH-1:0] mask_ext_s;

    // Shift field and mask into place, then merge over the base vector.
    always_comb begin
        data_ext_s = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, data} << pos;
        mask_ext_s = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, {IN_WIDTH{1'b1}}} << pos;
        if (en) begin
            result = (base & ~mask_ext_s) | data_ext_s;
        end else begin
            result = base;
        end
    end

endmodule

// File: rtl/ofm_packer.sv
// Narrow-to-wide gearbox: packs IN_WIDTH-bit result words LSB-first into
// OUT_WIDTH-bit AXI-Stream words, tagging the last word of each frame.
module ofm_packer #(
    parameter int IN_WIDTH  = acc_pkg::IN_WIDTH,
    parameter int OUT_WIDTH = acc_pkg::OUT_WIDTH,
    parameter int WORD_NUM  = acc_pkg::WORD_NUM,
    parameter int IN_NUM    = OUT_WIDTH * WORD_NUM / IN_WIDTH,
    parameter int ACC_WIDTH = OUT_WIDTH + IN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_conv_pulse,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    import acc_pkg::*;

    localparam int IC_W = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
    localparam int OC_W = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
    localparam logic [FILL_WIDTH-1:0] IN_STEP     = FILL_WIDTH'(IN_WIDTH);
    localparam logic [FILL_WIDTH-1:0] OUT_STEP    = FILL_WIDTH'(OUT_WIDTH);
    localparam logic [FILL_WIDTH-1:0] READY_LIMIT = FILL_WIDTH'(ACC_WIDTH - IN_WIDTH);
    localparam logic [IC_W-1:0]       IN_LAST     = IC_W'(IN_NUM - 1);
    localparam logic [OC_W-1:0]       OUT_LAST    = OC_W'(WORD_NUM - 1);

    logic [ACC_WIDTH-1:0]  acc_r;
    logic [FILL_WIDTH-1:0] fill_r;
    logic [IC_W-1:0]       in_cnt_r;
    logic [OC_W-1:0]       out_cnt_r;
    logic                  in_ready_r;
    logic                  m_valid_r;
    logic                  m_last_r;

    logic                  in_fire_s;
    logic                  out_fire_s;
    logic [ACC_WIDTH-1:0]  base_s;
    logic [FILL_WIDTH-1:0] pos_s;
    logic [ACC_WIDTH-1:0]  acc_next_s;
    logic [FILL_WIDTH-1:0] fill_next_s;
    logic [IC_W-1:0]       in_cnt_next_s;
    logic [OC_W-1:0]       out_cnt_next_s;

    assign in_ready = in_ready_r;
    assign m_valid  = m_valid_r;
    assign m_last   = m_last_r;
    assign m_data   = acc_r[OUT_WIDTH-1:0];

    // Handshakes, drain of the emitted word, fill level and frame counters.
    always_comb begin
        in_fire_s      = in_valid & in_ready_r;
        out_fire_s     = m_valid_r & m_ready;
        base_s         = acc_r;
        pos_s          = fill_r;
        fill_next_s    = fill_r;
        in_cnt_next_s  = in_cnt_r;
        out_cnt_next_s = out_cnt_r;
        if (out_fire_s) begin
            base_s         = acc_r >> OUT_WIDTH;
            pos_s          = fill_r - OUT_STEP;
            out_cnt_next_s = (out_cnt_r == OUT_LAST) ? {OC_W{1'b0}} : out_cnt_r + {{(OC_W-1){1'b0}}, 1'b1};
        end else begin
            base_s         = acc_r;
            pos_s          = fill_r;
            out_cnt_next_s = out_cnt_r;
        end
        if (in_fire_s) begin
            fill_next_s   = pos_s + IN_STEP;
            in_cnt_next_s = (in_cnt_r == IN_LAST) ? {IC_W{1'b0}} : in_cnt_r + {{(IC_W-1){1'b0}}, 1'b1};
        end else begin
            fill_next_s   = pos_s;
            in_cnt_next_s = in_cnt_r;
        end
    end

    packer_insert #(
        .ACC_WIDTH (ACC_WIDTH),
        .IN_WIDTH  (IN_WIDTH),
        .POS_WIDTH (FILL_WIDTH)
    ) u_insert (
        .base   (base_s),
        .pos    (pos_s),
        .data   (in_data),
        .en     (in_fire_s),
        .result (acc_next_s)
    );

    // State registers; handshake flags are precomputed from the next fill
    // level so every output leaves the block straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= {ACC_WIDTH{1'b0}};
            fill_r     <= {FILL_WIDTH{1'b0}};
            in_cnt_r   <= {IC_W{1'b0}};
            out_cnt_r  <= {OC_W{1'b0}};
            in_ready_r <= 1'b1;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
        end else if (start_conv_pulse) begin
            acc_r      <= {ACC_WIDTH{1'b0}};
            fill_r     <= {FILL_WIDTH{1'b0}};
            in_cnt_r   <= {IC_W{1'b0}};
            out_cnt_r  <= {OC_W{1'b0}};
            in_ready_r <= 1'b1;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
        end else begin
            acc_r      <= acc_next_s;
            fill_r     <= fill_next_s;
            in_cnt_r   <= in_cnt_next_s;
            out_cnt_r  <= out_cnt_next_s;
            in_ready_r <= (fill_next_s <= READY_LIMIT);
            m_valid_r  <= (fill_next_s >= OUT_STEP);
            m_last_r   <= (fill_next_s >= OUT_STEP) && (out_cnt_next_s == OUT_LAST);
        end
    end

endmodule
